spi_master: RTL and testbench



---
 rtl/spi_master_if.sv | 28 ++
 rtl/spi_master.sv | 136 +++++++++++++
 tb/tb_spi_master.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// Command port and SPI pins of the spi_master initiator.
//   start/tx_data      : transfer request and word to send
//   busy/done/rx_data  : transfer status, completion pulse, captured word
//   spi_clk/spi_cs/spi_mosi/spi_miso : physical SPI pins (mode 0, CS active-low)
// master modport is taken by the initiator, slave modport by its user/peer.
interface spi_master_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] tx_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rx_data;
  logic             spi_clk;
  logic             spi_cs;
  logic             spi_mosi;
  logic             spi_miso;

  modport master (
    input  start, tx_data, spi_miso,
    output busy, done, rx_data, spi_clk, spi_cs, spi_mosi
  );

  modport slave (
    output start, tx_data, spi_miso,
    input  busy, done, rx_data, spi_clk, spi_cs, spi_mosi
  );
endinterface

// File: rtl/spi_master.sv
// SPI initiator: shifts one WIDTH-bit word out on MOSI and captures WIDTH
// bits from MISO per transfer, MSB first, under one active-low chip select.
// Ports:
//   clk   : system clock, all state changes on posedge
//   rst_n : asynchronous active-low reset
//   bus   : spi_master_if.master (start/tx_data in, busy/done/rx_data out,
//           spi_clk/spi_cs/spi_mosi out, spi_miso in)
// Parameters: WIDTH bits per frame (>=2), CLK_DIV clk cycles per SCLK
// half-period (>=1).
module spi_master #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_master_if.master    bus
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] RELOAD   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } state_t;

  state_t           state,   state_nx;
  logic [DIV_W-1:0] div_cnt, div_nx;
  logic [CNT_W-1:0] bit_cnt, bit_nx;
  logic [WIDTH-1:0] tx_sr,   tx_nx;
  logic [WIDTH-1:0] rx_sr,   rx_nx;
  logic [WIDTH-1:0] rxd_q,   rxd_nx;
  logic             sclk_q,  sclk_nx;
  logic             cs_q,    cs_nx;
  logic             busy_q,  busy_nx;
  logic             done_q,  done_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rxd_q   <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      div_cnt <= div_nx;
      bit_cnt <= bit_nx;
      tx_sr   <= tx_nx;
      rx_sr   <= rx_nx;
      rxd_q   <= rxd_nx;
      sclk_q  <= sclk_nx;
      cs_q    <= cs_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
    end
  end

  // MOSI is taken straight from the shift register MSB; clearing the
  // register in HOLD gives the idle-low MOSI without a separate flop.
  always_comb begin
    state_nx = state;
    div_nx   = div_cnt;
    bit_nx   = bit_cnt;
    tx_nx    = tx_sr;
    rx_nx    = rx_sr;
    rxd_nx   = rxd_q;
    sclk_nx  = sclk_q;
    cs_nx    = cs_q;
    busy_nx  = busy_q;
    done_nx  = 1'b0;

    if (state == IDLE) begin
      if (bus.start) begin
        tx_nx    = bus.tx_data;
        cs_nx    = 1'b0;
        busy_nx  = 1'b1;
        bit_nx   = '0;
        div_nx   = RELOAD;
        state_nx = SETUP;
      end
    end else if (div_cnt != '0) begin
      div_nx = div_cnt - DIV_W'(1);
    end else begin
      div_nx = RELOAD;
      unique case (state)
        SETUP, LOW: begin
          sclk_nx  = 1'b1;
          rx_nx    = {rx_sr[WIDTH-2:0], bus.spi_miso};
          state_nx = HIGH;
        end
        HIGH: begin
          sclk_nx = 1'b0;
          if (bit_cnt != LAST_BIT) begin
            tx_nx    = {tx_sr[WIDTH-2:0], 1'b0};
            bit_nx   = bit_cnt + CNT_W'(1);
            state_nx = LOW;
          end else begin
            state_nx = HOLD;
          end
        end
        HOLD: begin
          cs_nx    = 1'b1;
          tx_nx    = '0;
          state_nx = GAP;
        end
        GAP: begin
          done_nx  = 1'b1;
          rxd_nx   = rx_sr;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rx_data  = rxd_q;
  assign bus.spi_clk  = sclk_q;
  assign bus.spi_cs   = cs_q;
  assign bus.spi_mosi = tx_sr[WIDTH-1];

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a 16-bit CLK_DIV=2 instance and an
// 8-bit CLK_DIV=1 instance driven by a bit-serial MISO target model.
module tb_spi_master;

  localparam int unsigned D0   = 2;
  localparam int unsigned NONE = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  logic loop_en;

  always #5 clk = ~clk;

  spi_master_if #(.WIDTH(16)) bus0 ();
  spi_master_if #(.WIDTH(8))  bus1 ();

  spi_master #(.WIDTH(16), .CLK_DIV(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  spi_master #(.WIDTH(8),  .CLK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus0.spi_miso = loop_en ? bus0.spi_mosi : 1'b0;

  // Mode-0 target for bus1: first bit at CS fall, next bit on each SCLK fall.
  logic [7:0] s1_sr = 8'h00;
  logic       s1_active = 1'b0;
  always @(negedge bus1.spi_cs or posedge bus1.spi_cs or negedge bus1.spi_clk) begin
    if (bus1.spi_cs) s1_active = 1'b0;
    else if (!s1_active) begin
      s1_active = 1'b1;
      s1_sr     = 8'hC3;
    end else s1_sr = {s1_sr[6:0], 1'b0};
  end
  assign bus1.spi_miso = s1_sr[7];

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned cs_low, busy_n, rises, falls, bad_runs, first_rise;
  int unsigned done_n, done_rel0, done_rel1, cs_rise, cs_fall2;
  logic [31:0] mosi_all;
  logic        mosi_r0;
  logic        rx_early;

  task automatic kick(input logic [15:0] data, input bit hold);
    @(negedge clk);
    bus0.start   = 1'b1;
    bus0.tx_data = data;
    @(posedge clk);
    #1;
    if (!hold) bus0.start = 1'b0;
  endtask

  // Observes bus0 for ncyc negedges; sample i reflects the state after edge E(i).
  task automatic watch(input int unsigned ncyc, input int unsigned drop_at,
                       input int unsigned poke_at, input logic [15:0] rx_hold);
    logic p_sclk, p_cs, p_mosi;
    int unsigned hrun, lrun;
    cs_low = 0; busy_n = 0; rises = 0; falls = 0; bad_runs = 0; first_rise = NONE;
    done_n = 0; done_rel0 = NONE; done_rel1 = NONE; cs_rise = NONE; cs_fall2 = NONE;
    mosi_all = '0; mosi_r0 = 1'b0; rx_early = 1'b0;
    p_sclk = 1'b0; p_cs = 1'b0; p_mosi = 1'b0; hrun = 0; lrun = 0;
    for (int unsigned i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (i == drop_at) bus0.start = 1'b0;
      if (i == poke_at) begin
        bus0.start   = 1'b1;
        bus0.tx_data = '0;
      end
      if (poke_at != NONE && i == poke_at + 1) bus0.start = 1'b0;
      if (i == 0) mosi_r0 = bus0.spi_mosi;
      if (!bus0.spi_cs) cs_low++;
      if (bus0.busy) busy_n++;
      if (!bus0.spi_cs && p_cs) begin
        if (cs_fall2 == NONE) cs_fall2 = i;
        lrun = 0;
      end
      if (bus0.spi_cs && !p_cs && cs_rise == NONE) cs_rise = i;
      if (bus0.spi_clk && !p_sclk) begin
        rises++;
        if (first_rise == NONE) first_rise = i;
        if (lrun != D0) bad_runs++;
        hrun = 0;
      end
      if (!bus0.spi_clk && p_sclk) begin
        falls++;
        if (hrun != D0) bad_runs++;
        mosi_all = {mosi_all[30:0], p_mosi};
        lrun = 0;
      end
      if (bus0.spi_clk) hrun++;
      else lrun++;
      if (bus0.done) begin
        if (done_n == 0) done_rel0 = i;
        else if (done_n == 1) done_rel1 = i;
        done_n++;
      end
      if (done_n == 0 && bus0.rx_data !== rx_hold) rx_early = 1'b1;
      p_sclk = bus0.spi_clk;
      p_cs   = bus0.spi_cs;
      p_mosi = bus0.spi_mosi;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; loop_en = 1'b0;
    bus0.start = 1'b0; bus0.tx_data = '0;
    bus1.start = 1'b0; bus1.tx_data = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus0.spi_cs, bus0.spi_clk, bus0.spi_mosi, bus0.busy, bus0.done} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_pins0: got %b expected 10000",
        {bus0.spi_cs, bus0.spi_clk, bus0.spi_mosi, bus0.busy, bus0.done});
    end
    n_tests++;
    if (bus0.rx_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_rx0: got %h expected 0000", bus0.rx_data);
    end
    n_tests++;
    if ({bus1.spi_cs, bus1.spi_clk, bus1.spi_mosi, bus1.busy, bus1.done} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_pins1: got %b expected 10000",
        {bus1.spi_cs, bus1.spi_clk, bus1.spi_mosi, bus1.busy, bus1.done});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_defaults();
    loop_en = 1'b0;
    kick(16'h0703, 1'b0);
    watch(80, NONE, NONE, 16'h0000);
    n_tests++; if (cs_low !== 66) begin n_fail++; $display("FAIL def_cs_low: got %0d expected 66", cs_low); end
    n_tests++; if (cs_rise !== 66) begin n_fail++; $display("FAIL def_cs_rise: got %0d expected 66", cs_rise); end
    n_tests++; if (rises !== 16) begin n_fail++; $display("FAIL def_rises: got %0d expected 16", rises); end
    n_tests++; if (falls !== 16) begin n_fail++; $display("FAIL def_falls: got %0d expected 16", falls); end
    n_tests++; if (bad_runs !== 0) begin n_fail++; $display("FAIL def_half_periods: got %0d bad expected 0", bad_runs); end
    n_tests++; if (first_rise !== 2) begin n_fail++; $display("FAIL def_first_rise: got %0d expected 2", first_rise); end
    n_tests++; if (mosi_r0 !== 1'b0) begin n_fail++; $display("FAIL def_mosi_first: got %b expected 0", mosi_r0); end
    n_tests++; if (mosi_all[15:0] !== 16'h0703) begin n_fail++; $display("FAIL def_mosi_word: got %h expected 0703", mosi_all[15:0]); end
    n_tests++; if (done_rel0 !== 68) begin n_fail++; $display("FAIL def_done_cycle: got %0d expected 68", done_rel0); end
    n_tests++; if (done_n !== 1) begin n_fail++; $display("FAIL def_done_width: got %0d expected 1", done_n); end
    n_tests++; if (busy_n !== 68) begin n_fail++; $display("FAIL def_busy_len: got %0d expected 68", busy_n); end
    n_tests++; if (bus0.rx_data !== 16'h0000) begin n_fail++; $display("FAIL def_rx: got %h expected 0000", bus0.rx_data); end
  endtask

  task automatic test_loopback();
    loop_en = 1'b1;
    kick(16'hA55A, 1'b0);
    watch(80, NONE, NONE, 16'h0000);
    n_tests++; if (mosi_r0 !== 1'b1) begin n_fail++; $display("FAIL lb_mosi_first: got %b expected 1", mosi_r0); end
    n_tests++; if (rx_early !== 1'b0) begin n_fail++; $display("FAIL lb_rx_early: got %b expected 0", rx_early); end
    n_tests++; if (done_rel0 !== 68) begin n_fail++; $display("FAIL lb_done_cycle: got %0d expected 68", done_rel0); end
    n_tests++; if (bus0.rx_data !== 16'hA55A) begin n_fail++; $display("FAIL lb_rx: got %h expected a55a", bus0.rx_data); end
  endtask

  task automatic test_back_to_back();
    loop_en = 1'b1;
    kick(16'h1234, 1'b1);
    bus0.tx_data = 16'hFFFF;
    watch(160, 100, NONE, 16'hA55A);
    n_tests++; if (done_n !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", done_n); end
    n_tests++; if (done_rel1 - done_rel0 !== 69) begin n_fail++; $display("FAIL b2b_done_spacing: got %0d expected 69", done_rel1 - done_rel0); end
    n_tests++; if (cs_fall2 - cs_rise !== 3) begin n_fail++; $display("FAIL b2b_cs_gap: got %0d expected 3", cs_fall2 - cs_rise); end
    n_tests++; if (mosi_all !== 32'h1234FFFF) begin n_fail++; $display("FAIL b2b_mosi: got %h expected 1234ffff", mosi_all); end
    n_tests++; if (bad_runs !== 0) begin n_fail++; $display("FAIL b2b_half_periods: got %0d bad expected 0", bad_runs); end
    n_tests++; if (rx_early !== 1'b0) begin n_fail++; $display("FAIL b2b_rx_early: got %b expected 0", rx_early); end
    n_tests++; if (bus0.rx_data !== 16'hFFFF) begin n_fail++; $display("FAIL b2b_rx: got %h expected ffff", bus0.rx_data); end
  endtask

  task automatic test_start_while_busy();
    loop_en = 1'b1;
    kick(16'hFFFF, 1'b0);
    watch(100, NONE, 20, 16'hFFFF);
    n_tests++; if (mosi_all[15:0] !== 16'hFFFF) begin n_fail++; $display("FAIL swb_mosi: got %h expected ffff", mosi_all[15:0]); end
    n_tests++; if (done_n !== 1) begin n_fail++; $display("FAIL swb_done_count: got %0d expected 1", done_n); end
    n_tests++; if (cs_fall2 !== NONE) begin n_fail++; $display("FAIL swb_restart: got cs fall at %0d expected none", cs_fall2); end
    n_tests++; if (bus0.rx_data !== 16'hFFFF) begin n_fail++; $display("FAIL swb_rx: got %h expected ffff", bus0.rx_data); end
  endtask

  task automatic test_reset_mid();
    loop_en = 1'b1;
    kick(16'h0703, 1'b0);
    repeat (30) @(negedge clk);
    n_tests++; if ({bus0.spi_cs, bus0.busy} !== 2'b01) begin n_fail++; $display("FAIL rm_in_frame: got %b expected 01", {bus0.spi_cs, bus0.busy}); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus0.spi_cs, bus0.spi_clk, bus0.spi_mosi, bus0.busy, bus0.done} !== 5'b10000) begin
      n_fail++; $display("FAIL rm_async_pins: got %b expected 10000",
        {bus0.spi_cs, bus0.spi_clk, bus0.spi_mosi, bus0.busy, bus0.done});
    end
    n_tests++; if (bus0.rx_data !== 16'h0000) begin n_fail++; $display("FAIL rm_async_rx: got %h expected 0000", bus0.rx_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    watch(80, NONE, NONE, 16'h0000);
    n_tests++; if (done_n !== 0) begin n_fail++; $display("FAIL rm_no_done: got %0d expected 0", done_n); end
    n_tests++; if (cs_low !== 0) begin n_fail++; $display("FAIL rm_cs_idle: got %0d expected 0", cs_low); end
    kick(16'h0703, 1'b0);
    watch(80, NONE, NONE, 16'h0000);
    n_tests++; if (done_rel0 !== 68) begin n_fail++; $display("FAIL rm_done_cycle: got %0d expected 68", done_rel0); end
    n_tests++; if (busy_n !== 68) begin n_fail++; $display("FAIL rm_busy_len: got %0d expected 68", busy_n); end
    n_tests++; if (mosi_all[15:0] !== 16'h0703) begin n_fail++; $display("FAIL rm_mosi: got %h expected 0703", mosi_all[15:0]); end
    n_tests++; if (bus0.rx_data !== 16'h0703) begin n_fail++; $display("FAIL rm_rx: got %h expected 0703", bus0.rx_data); end
  endtask

  task automatic test_narrow();
    int unsigned d_rel, b_n, cs_n;
    logic [7:0]  mw;
    logic        p_sclk, p_mosi;
    d_rel = NONE; b_n = 0; cs_n = 0; mw = '0; p_sclk = 1'b0; p_mosi = 1'b0;
    @(negedge clk);
    bus1.start   = 1'b1;
    bus1.tx_data = 8'h5A;
    @(posedge clk);
    #1 bus1.start = 1'b0;
    for (int unsigned i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus1.busy) b_n++;
      if (!bus1.spi_cs) cs_n++;
      if (bus1.done && d_rel == NONE) d_rel = i;
      if (!bus1.spi_clk && p_sclk) mw = {mw[6:0], p_mosi};
      p_sclk = bus1.spi_clk;
      p_mosi = bus1.spi_mosi;
    end
    n_tests++; if (bus1.rx_data !== 8'hC3) begin n_fail++; $display("FAIL n8_rx: got %h expected c3", bus1.rx_data); end
    n_tests++; if (d_rel !== 18) begin n_fail++; $display("FAIL n8_done_cycle: got %0d expected 18", d_rel); end
    n_tests++; if (b_n !== 18) begin n_fail++; $display("FAIL n8_busy_len: got %0d expected 18", b_n); end
    n_tests++; if (cs_n !== 17) begin n_fail++; $display("FAIL n8_cs_low: got %0d expected 17", cs_n); end
    n_tests++; if (mw !== 8'h5A) begin n_fail++; $display("FAIL n8_mosi: got %h expected 5a", mw); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_defaults();
    test_loopback();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid();
    test_narrow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
